// File: rtl/sy_ppl_lsu_dc_arb_pkg.sv
// Shared types and constants for the LSU D$ request-port arbiter.
// Port indices, request/response payloads and the grant-hold state encoding.
package sy_ppl_lsu_dc_arb_pkg;

    localparam int unsigned DC_ARB_NREQ   = 3;
    localparam int unsigned DC_ARB_OUTSTD = 4;

    localparam int unsigned PTW_PORT = 0;
    localparam int unsigned LSU_PORT = 1;
    localparam int unsigned SB_PORT  = 2;

    typedef enum logic [1:0] {
        MEM_LOAD,
        MEM_STORE,
        MEM_AMO
    } mem_op_e;

    typedef enum logic [3:0] {
        AMO_NONE,
        AMO_SWAP,
        AMO_ADD,
        AMO_AND,
        AMO_OR,
        AMO_XOR,
        AMO_MAX,
        AMO_MIN,
        AMO_LR,
        AMO_SC
    } amo_op_e;

    typedef struct packed {
        logic [39:0] paddr;
        logic [63:0] wdata;
        logic [1:0]  size;
        mem_op_e     mem_op;
        amo_op_e     amo_op;
        logic [5:0]  rob_idx;
        logic [4:0]  rdst;
    } dcache_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        exc;
        logic [4:0]  exc_cause;
    } dcache_rsp_t;

    typedef enum logic {
        GNT_FREE,
        GNT_HOLD
    } gnt_state_e;

    // Round-robin candidate for offset k from ptr, cycling over ports 1..nreq-1.
    function automatic int unsigned rr_port(int unsigned ptr, int unsigned k, int unsigned nreq);
        return 1 + ((ptr - 1 + k) % (nreq - 1));
    endfunction

endpackage

// File: rtl/sy_ppl_lsu_dc_arb_if.sv
// Requester-side and D$-side bus of the LSU D$ arbiter.
// slave = arbiter view, master = environment (requesters plus D$) view.
interface sy_ppl_lsu_dc_arb_if #(
    parameter int unsigned NREQ = sy_ppl_lsu_dc_arb_pkg::DC_ARB_NREQ
);
    import sy_ppl_lsu_dc_arb_pkg::*;

    logic [NREQ-1:0] req_vld_i;
    logic [NREQ-1:0] req_rdy_o;
    logic [NREQ-1:0] req_lock_i;
    dcache_req_t     req_i [NREQ];

    logic            dc_req_vld_o;
    logic            dc_req_rdy_i;
    dcache_req_t     dc_req_o;

    logic            dc_rsp_vld_i;
    dcache_rsp_t     dc_rsp_i;

    logic [NREQ-1:0] rsp_vld_o;
    dcache_rsp_t     rsp_o;

    modport slave (
        input  req_vld_i, req_lock_i, req_i, dc_req_rdy_i, dc_rsp_vld_i, dc_rsp_i,
        output req_rdy_o, dc_req_vld_o, dc_req_o, rsp_vld_o, rsp_o
    );

    modport master (
        output req_vld_i, req_lock_i, req_i, dc_req_rdy_i, dc_rsp_vld_i, dc_rsp_i,
        input  req_rdy_o, dc_req_vld_o, dc_req_o, rsp_vld_o, rsp_o
    );

endinterface

// File: rtl/sy_ppl_lsu_dc_arb_fifo.sv
// In-order FIFO of outstanding D$ request origins with per-entry kill bit.
// A bulk kill marks every entry whose id matches, so its response is dropped on pop.
module sy_ppl_lsu_dc_arb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push,
    input  logic [IDW-1:0] push_id,
    input  logic           pop,
    input  logic           kill_en,
    input  logic [IDW-1:0] kill_id,
    output logic           full,
    output logic           empty,
    output logic [IDW-1:0] head_id,
    output logic           head_kill
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]      wr_q;
    logic [PW:0]      rd_q;
    logic [IDW-1:0]   id_q [DEPTH];
    logic [DEPTH-1:0] kill_q;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head_id   = id_q[rd_q[PW-1:0]];
    assign head_kill = kill_q[rd_q[PW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            kill_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            // Stale slots may get marked too; a push rewrites the kill bit anyway.
            if (kill_en) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (id_q[i] == kill_id) begin
                        kill_q[i] <= 1'b1;
                    end
                end
            end
            if (push) begin
                id_q[wr_q[PW-1:0]]   <= push_id;
                kill_q[wr_q[PW-1:0]] <= 1'b0;
                wr_q                 <= wr_q + (PW+1)'(1);
            end
            if (pop) begin
                rd_q <= rd_q + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sy_ppl_lsu_dc_arb.sv
// Arbiter for the single D$ request port between PTW, LSU IQ head and store buffer.
// Priority: held grant > lock > starved port > port 0 > round-robin over 1..NREQ-1.
module sy_ppl_lsu_dc_arb #(
    parameter int unsigned NREQ       = sy_ppl_lsu_dc_arb_pkg::DC_ARB_NREQ,
    parameter int unsigned OUTSTD     = sy_ppl_lsu_dc_arb_pkg::DC_ARB_OUTSTD,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned LSU_PORT   = sy_ppl_lsu_dc_arb_pkg::LSU_PORT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    sy_ppl_lsu_dc_arb_if.slave  bus
);
    import sy_ppl_lsu_dc_arb_pkg::*;

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = $clog2(STARVE_MAX + 1);

    typedef logic [IDW-1:0] id_t;

    gnt_state_e    state_q;
    gnt_state_e    state_d;
    id_t           held_q;
    id_t           lock_id_q;
    logic          lock_vld_q;
    id_t           rr_ptr_q;
    logic [CW-1:0] starve_q [NREQ];

    id_t           grant;
    id_t           rr_idx;
    logic          gnt_found;
    logic          hs;
    logic          pop;
    logic          full;
    logic          empty;
    id_t           head_id;
    logic          head_kill;

    always_comb begin
        grant     = '0;
        gnt_found = 1'b0;
        rr_idx    = '0;
        if (state_q == GNT_HOLD && bus.req_vld_i[held_q]) begin
            grant     = held_q;
            gnt_found = 1'b1;
        end else if (lock_vld_q && bus.req_vld_i[lock_id_q]) begin
            grant     = lock_id_q;
            gnt_found = 1'b1;
        end else begin
            // Scan downwards so the lowest starved index ends up winning.
            for (int unsigned i = NREQ - 1; i >= 1; i--) begin
                if (bus.req_vld_i[i] && starve_q[i] == CW'(STARVE_MAX)) begin
                    grant     = id_t'(i);
                    gnt_found = 1'b1;
                end
            end
            if (!gnt_found && bus.req_vld_i[0]) begin
                grant     = '0;
                gnt_found = 1'b1;
            end
            if (!gnt_found) begin
                // Offset 0 (rr_ptr itself) is visited last so it has precedence.
                for (int unsigned k = NREQ - 1; k >= 1; k--) begin
                    rr_idx = id_t'(rr_port(32'(rr_ptr_q), k - 1, NREQ));
                    if (bus.req_vld_i[rr_idx]) begin
                        grant     = rr_idx;
                        gnt_found = 1'b1;
                    end
                end
            end
        end
    end

    assign hs  = bus.dc_req_vld_o && bus.dc_req_rdy_i;
    assign pop = bus.dc_rsp_vld_i && !empty;

    always_comb begin
        bus.dc_req_vld_o = gnt_found && !full && !flush_i && !rst_i;
        bus.dc_req_o     = '0;
        bus.req_rdy_o    = '0;
        if (bus.dc_req_vld_o) begin
            bus.dc_req_o = bus.req_i[grant];
        end
        if (hs) begin
            bus.req_rdy_o[grant] = 1'b1;
        end
    end

    always_comb begin
        bus.rsp_vld_o = '0;
        bus.rsp_o     = bus.dc_rsp_i;
        if (pop && !head_kill) begin
            bus.rsp_vld_o[head_id] = 1'b1;
        end
    end

    // Offering without acceptance pins the grant; flush drops vld and so releases it.
    always_comb begin
        state_d = GNT_FREE;
        if (bus.dc_req_vld_o && !bus.dc_req_rdy_i) begin
            state_d = GNT_HOLD;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= GNT_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held_q     <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            rr_ptr_q   <= id_t'(1);
        end else begin
            if (state_d == GNT_HOLD) begin
                held_q <= grant;
            end
            if (flush_i) begin
                lock_vld_q <= 1'b0;
            end else if (hs) begin
                lock_vld_q <= bus.req_lock_i[grant];
                lock_id_q  <= grant;
            end
            if (hs && grant != '0) begin
                rr_ptr_q <= (grant == id_t'(NREQ - 1)) ? id_t'(1) : grant + id_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREQ; i++) begin
                if (flush_i || (hs && grant == id_t'(i))) begin
                    starve_q[i] <= '0;
                end else if (bus.req_vld_i[i] && starve_q[i] != CW'(STARVE_MAX)) begin
                    starve_q[i] <= starve_q[i] + CW'(1);
                end
            end
        end
    end

    sy_ppl_lsu_dc_arb_fifo #(
        .DEPTH (OUTSTD),
        .IDW   (IDW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (hs),
        .push_id   (grant),
        .pop       (pop),
        .kill_en   (flush_i),
        .kill_id   (id_t'(LSU_PORT)),
        .full      (full),
        .empty     (empty),
        .head_id   (head_id),
        .head_kill (head_kill)
    );

    rsp_without_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) !(bus.dc_rsp_vld_i && empty)
    );

endmodule
